aes256_axis_bridge: RTL and testbench
=====================================

AES256_AXIS_BRIDGE -- requirements
Module: aes256_axis_bridge

Interface
REQ-001 Parameter WDOG_CYCLES, default 1024: number of WAIT cycles before the watchdog timeout fires.
REQ-002 clk  in  1  clock; all logic is rising-edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 s_axis_tdata  in  32  plaintext/ciphertext/seed word.
REQ-005 s_axis_tvalid/s_axis_tready  in/out  1  input beat handshake.
REQ-006 s_axis_tlast  in  1  last beat of the block.
REQ-007 s_axis_tuser  in  2  mode: 00 encrypt, 01 decrypt, 10 keygen, 11 invalid; sampled on the first beat only.
REQ-008 m_axis_tdata  out  32  result word.
REQ-009 m_axis_tvalid/m_axis_tready  out/in  1  output beat handshake.
REQ-010 m_axis_tlast  out  1  marks the 4th result word.
REQ-011 dev_data_in  out  128  block presented to the AES device.
REQ-012 dev_ctrl_in  out  1  one-cycle strobe qualifying dev_data_in and dev_mode.
REQ-013 dev_mode  out  2  mode presented to the device.
REQ-014 dev_data_out  in  128  device result.
REQ-015 dev_ctrl_out  in  1  one-cycle strobe qualifying dev_data_out.
REQ-016 busy  out  1  high in every state except COLLECT.
REQ-017 err  out  2  sticky flags: [0] watchdog timeout, [1] invalid mode.

Function
REQ-018 States: COLLECT, ISSUE, WAIT, DRAIN.
REQ-019 COLLECT: s_axis_tready=1; accepted beat k (0..3) is written to bits [127-32k -: 32], so beat 0 is the MSW.
REQ-020 Early tlast (beat k<3): the remaining words are zero-filled and the block is treated as complete.
REQ-021 A 4th beat without tlast also completes the block; tlast is not required.
REQ-022 On block completion: next state is ISSUE and s_axis_tready drops the following cycle.
REQ-023 Invalid mode 11: the block is discarded, err[1] is set, and the FSM returns to COLLECT; no dev_ctrl_in pulse is issued.
REQ-024 ISSUE lasts exactly one cycle: dev_ctrl_in=1, dev_data_in and dev_mode driven; then WAIT.
REQ-025 dev_data_in and dev_mode hold their value until the next ISSUE.
REQ-026 WAIT: on dev_ctrl_out=1, dev_data_out is captured in the same cycle.
REQ-027 After the capture in WAIT, encrypt/decrypt go to DRAIN; keygen goes to COLLECT and produces no output beats.
REQ-028 dev_ctrl_out outside WAIT is ignored.
REQ-029 DRAIN: words are presented MSW first; m_axis_tvalid is held until m_axis_tready.
REQ-030 DRAIN: m_axis_tdata is stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-031 DRAIN: m_axis_tlast=1 on word 3; after the word-3 handshake, s_axis_tready=1 on the next cycle.
REQ-032 Minimum latency is 1 cycle from the last input handshake to dev_ctrl_in, plus 1 cycle from dev_ctrl_out to m_axis_tvalid.
REQ-033 There is no overlap between blocks: only one block is in flight at a time.

Reset
REQ-034 While resetn=0, all outputs are 0, the state is COLLECT, the beat counters are 0, and err=00.
REQ-035 s_axis_tready rises on the first clk edge after resetn deasserts.
REQ-036 Reset mid-block or mid-drain discards all partial data; no m_axis beat follows reset release until a new block completes.

Configuration
REQ-037 The watchdog feature is controlled by macro AES_BRIDGE_WDOG_EN.
REQ-038 With AES_BRIDGE_WDOG_EN defined: the counter clears on entering WAIT; when it reaches WDOG_CYCLES the FSM goes to COLLECT and err[0] is set.
REQ-039 With AES_BRIDGE_WDOG_EN defined: a dev_ctrl_out arriving in the same cycle as the timeout wins (the result is captured, no error).
REQ-040 Without AES_BRIDGE_WDOG_EN: WAIT persists indefinitely, err[0] is tied to 0, and no counter logic is present.

Structure
REQ-041 Package aes256_pkg holds the mode constants (MODE_ENC, MODE_DEC, MODE_KG, MODE_INV), the state enum, WORDS_PER_BLOCK=4 and BLOCK_W=128.
REQ-042 One sub-module, aes256_wdog (load/count/expire), is instantiated only under AES_BRIDGE_WDOG_EN.

Verification
REQ-043 Encrypt round trip: 4 beats 00112233, 44556677, 8899AABB, CCDDEEFF with tuser=00 -> dev_data_in=00112233_44556677_8899AABB_CCDDEEFF; dev_ctrl_in pulses exactly once; dev_mode=00.
REQ-044 Output ordering: device returns 69C4E0D8_6A7B0430_D8CDB780_70B4C55A -> 4 output beats in that word order; tlast on the 4th beat only.
REQ-045 Output backpressure: m_axis_tready low for 5 cycles during DRAIN -> tdata stable across the stall; no word is lost or duplicated.
REQ-046 Early tlast: 2 beats DEADBEEF, CAFEF00D with tlast on beat 1 -> dev_data_in=DEADBEEF_CAFEF00D_00000000_00000000.
REQ-047 Invalid mode and keygen: a tuser=11 block sets err[1] with no dev_ctrl_in pulse; a tuser=10 block followed by dev_ctrl_out produces no m_axis beat and returns to COLLECT.
REQ-048 Watchdog: with the macro defined and WDOG_CYCLES=16, no dev_ctrl_out -> err[0]=1 at WAIT cycle 16 and s_axis_tready=1 the next cycle.
REQ-049 Reset mid-drain: resetn pulsed after 2 of 4 output beats -> all outputs return to 0 and no further beats appear.

Source files
------------

// File: rtl/aes256_pkg.sv
// Shared constants, state encoding and word-slicing helper for the AES-256 stream bridge.
package aes256_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = 128;

  localparam logic [1:0] MODE_ENC = 2'b00;
  localparam logic [1:0] MODE_DEC = 2'b01;
  localparam logic [1:0] MODE_KG  = 2'b10;
  localparam logic [1:0] MODE_INV = 2'b11;

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, DRAIN} bridgeState;

  // Word 0 is the most significant word of the block.
  function automatic logic [31:0] wordAt(input logic [BLOCK_W-1:0] blk, input logic [1:0] idx);
    return blk[BLOCK_W-1-32*int'(idx) -: 32];
  endfunction

endpackage

// File: rtl/aes256_wdog.sv
// WAIT-state watchdog, built only with AES_BRIDGE_WDOG_EN: load clears, count advances,
// expire is asserted combinationally during the WDOG_CYCLES-th counted cycle.
`ifdef AES_BRIDGE_WDOG_EN
module aes256_wdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expire = count && (cnt == CW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/aes256_axis_bridge.sv
// Packs up to 4 s_axis beats into a block, strobes the AES device, then drains its result on m_axis.
// 1 cycle last beat -> dev_ctrl_in, 1 cycle dev_ctrl_out -> m_axis_tvalid; s_axis stalls while a block is in flight. Watchdog: AES_BRIDGE_WDOG_EN.
module aes256_axis_bridge #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [31:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  input  logic [1:0]   s_axis_tuser,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic [127:0] dev_data_in,
  output logic         dev_ctrl_in,
  output logic [1:0]   dev_mode,
  input  logic [127:0] dev_data_out,
  input  logic         dev_ctrl_out,
  output logic         busy,
  output logic [1:0]   err
);
  import aes256_pkg::*;

  if (WDOG_CYCLES < 1) begin : gBadCfg
    $error("WDOG_CYCLES must be at least 1");
  end

  bridgeState         state;
  logic [1:0]         inCnt;
  logic [1:0]         outCnt;
  logic [1:0]         modeReg;
  logic [BLOCK_W-1:0] colBuf;
  logic [BLOCK_W-1:0] resBuf;
  logic               sTready;
  logic               mTvalid;
  logic [31:0]        mTdata;
  logic               mTlast;
  logic [BLOCK_W-1:0] devDataReg;
  logic               devCtrlReg;
  logic [1:0]         devModeReg;
  logic               busyReg;
  logic               errInv;

  logic [BLOCK_W-1:0] nextBlk;
  logic [1:0]         beatMode;
  logic               blockDone;

  // Beat 0 clears the lower words, so an early tlast leaves them zero-filled.
  always_comb begin
    nextBlk = colBuf;
    if (inCnt == 2'd0) begin
      nextBlk = {s_axis_tdata, {(BLOCK_W-32){1'b0}}};
    end else begin
      nextBlk[BLOCK_W-1-32*int'(inCnt) -: 32] = s_axis_tdata;
    end
    beatMode  = (inCnt == 2'd0) ? s_axis_tuser : modeReg;
    blockDone = s_axis_tlast || (inCnt == 2'(WORDS_PER_BLOCK - 1));
  end

`ifdef AES_BRIDGE_WDOG_EN
  logic errWdog;
  logic wdogExpire;

  aes256_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) uWdog (
    .clk    (clk),
    .resetn (resetn),
    .load   (state == ISSUE),
    .count  (state == WAIT),
    .expire (wdogExpire)
  );

  assign err = {errInv, errWdog};
`else
  assign err = {errInv, 1'b0};
`endif

  assign s_axis_tready = sTready;
  assign m_axis_tvalid = mTvalid;
  assign m_axis_tdata  = mTdata;
  assign m_axis_tlast  = mTlast;
  assign dev_data_in   = devDataReg;
  assign dev_ctrl_in   = devCtrlReg;
  assign dev_mode      = devModeReg;
  assign busy          = busyReg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= COLLECT;
      inCnt      <= '0;
      outCnt     <= '0;
      modeReg    <= MODE_ENC;
      colBuf     <= '0;
      resBuf     <= '0;
      sTready    <= 1'b0;
      mTvalid    <= 1'b0;
      mTdata     <= '0;
      mTlast     <= 1'b0;
      devDataReg <= '0;
      devCtrlReg <= 1'b0;
      devModeReg <= MODE_ENC;
      busyReg    <= 1'b0;
      errInv     <= 1'b0;
`ifdef AES_BRIDGE_WDOG_EN
      errWdog    <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          sTready <= 1'b1;
          if (s_axis_tvalid && sTready) begin
            colBuf <= nextBlk;
            if (inCnt == 2'd0) modeReg <= s_axis_tuser;
            if (blockDone) begin
              inCnt <= '0;
              // An invalid block is dropped here and never reaches the device.
              if (beatMode == MODE_INV) begin
                errInv <= 1'b1;
              end else begin
                state      <= ISSUE;
                sTready    <= 1'b0;
                busyReg    <= 1'b1;
                devCtrlReg <= 1'b1;
                devDataReg <= nextBlk;
                devModeReg <= beatMode;
              end
            end else begin
              inCnt <= inCnt + 2'd1;
            end
          end
        end
        ISSUE: begin
          devCtrlReg <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (dev_ctrl_out) begin
            resBuf <= dev_data_out;
            if (devModeReg == MODE_KG) begin
              state   <= COLLECT;
              sTready <= 1'b1;
              busyReg <= 1'b0;
            end else begin
              state   <= DRAIN;
              mTvalid <= 1'b1;
              mTdata  <= wordAt(dev_data_out, 2'd0);
              mTlast  <= 1'b0;
              outCnt  <= '0;
            end
          end
`ifdef AES_BRIDGE_WDOG_EN
          else if (wdogExpire) begin
            state   <= COLLECT;
            sTready <= 1'b1;
            busyReg <= 1'b0;
            errWdog <= 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (m_axis_tready) begin
            if (outCnt == 2'(WORDS_PER_BLOCK - 1)) begin
              mTvalid <= 1'b0;
              mTlast  <= 1'b0;
              mTdata  <= '0;
              state   <= COLLECT;
              sTready <= 1'b1;
              busyReg <= 1'b0;
            end else begin
              outCnt <= outCnt + 2'd1;
              mTdata <= wordAt(resBuf, outCnt + 2'd1);
              mTlast <= (outCnt == 2'(WORDS_PER_BLOCK - 2));
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_axis_bridge.sv
// Randomized self-checking bench for aes256_axis_bridge; the watchdog scenario runs when AES_BRIDGE_WDOG_EN is defined.
module tb_aes256_axis_bridge;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [31:0]  s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [1:0]   s_axis_tuser = '0;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic [127:0] dev_data_in;
  logic         dev_ctrl_in;
  logic [1:0]   dev_mode;
  logic [127:0] dev_data_out = '0;
  logic         dev_ctrl_out = 1'b0;
  logic         busy;
  logic [1:0]   err;

  always #5 clk = ~clk;

  aes256_axis_bridge #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .dev_data_in(dev_data_in), .dev_ctrl_in(dev_ctrl_in), .dev_mode(dev_mode),
    .dev_data_out(dev_data_out), .dev_ctrl_out(dev_ctrl_out),
    .busy(busy), .err(err)
  );

  int errors = 0;
  int checks = 0;
  logic [32:0] outQ[$];
  int ctrlPulses = 0;
  int stallViol = 0;
  logic prevStall = 1'b0;
  logic [31:0] prevData = '0;
  logic [31:0] beatWords[4];

  // Passive observer: accepted output beats, device strobes, data stability under stall.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) outQ.push_back({m_axis_tlast, m_axis_tdata});
    if (dev_ctrl_in) ctrlPulses++;
    if (resetn && prevStall && (!m_axis_tvalid || m_axis_tdata !== prevData)) stallViol++;
    prevStall = resetn && m_axis_tvalid && !m_axis_tready;
    prevData  = m_axis_tdata;
  end

  initial begin
    #400000;
    $display("FAIL sim_timeout: simulation did not finish, got hang want finish");
    $fatal(1);
  end

  // Reference: the first n words placed MSW first, remaining words zero.
  function automatic logic [127:0] expBlock(input int n);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r = r | (128'(beatWords[k]) << (32 * (3 - k)));
    return r;
  endfunction

  function automatic logic [32:0] expBeat(input logic [127:0] res, input int k);
    logic [127:0] t;
    t = res >> (32 * (3 - k));
    return {(k == 3), t[31:0]};
  endfunction

  function automatic logic [32:0] gotBeat(input int k);
    if (k < outQ.size()) return outQ[k];
    return 'x;
  endfunction

  task automatic randWords();
    for (int k = 0; k < 4; k++) beatWords[k] = $urandom;
  endtask

  task automatic sendBlock(input int n, input logic [1:0] mode0, input logic [1:0] modeRest,
                           input bit useLast, output bit ok);
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      int waitCyc;
      waitCyc = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beatWords[k];
      s_axis_tuser  = (k == 0) ? mode0 : modeRest;
      s_axis_tlast  = useLast && (k == n - 1);
      @(negedge clk);
      while (!s_axis_tready && waitCyc < 50) begin
        waitCyc++;
        @(negedge clk);
      end
      if (!s_axis_tready) ok = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic devReply(input logic [127:0] res, input int delay, output int lat, output bit ok);
    lat = 0;
    @(negedge clk);
    while (!dev_ctrl_in && lat < 30) begin
      lat++;
      @(negedge clk);
    end
    ok = dev_ctrl_in;
    if (ok) begin
      @(posedge clk);
      repeat (delay) @(posedge clk);
      #1 dev_ctrl_out = 1'b1;
      dev_data_out = res;
      @(posedge clk); #1;
      dev_ctrl_out = 1'b0;
    end
  endtask

  task automatic drain(input int target, input bit randReady, output bit ok);
    for (int c = 0; c < 300 && outQ.size() < target; c++) begin
      if (randReady) m_axis_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
    ok = (outQ.size() >= target);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, dev_data_in, dev_ctrl_in, dev_mode, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want all zero", {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, dev_data_in, dev_ctrl_in, dev_mode, busy, err});
    end
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL tready_before_edge: got %b want 0", s_axis_tready); end
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL tready_after_edge: got tready=%b busy=%b want 1 0", s_axis_tready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_encrypt();
    logic [127:0] res;
    bit ok, okR;
    int lat, p0;
    res = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    beatWords = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    p0 = ctrlPulses;
    outQ.delete();
    sendBlock(4, 2'b00, 2'b00, 1'b1, ok);
    devReply(res, 0, lat, okR);
    checks++;
    if (!ok || !okR || lat != 0) begin errors++; $display("FAIL enc_issue_latency: got ok=%b/%b lat=%0d want 1/1 0", ok, okR, lat); end
    checks++;
    if (dev_data_in !== expBlock(4) || dev_mode !== 2'b00) begin
      errors++; $display("FAIL enc_dev_block: got %h mode %b want %h mode 00", dev_data_in, dev_mode, expBlock(4));
    end
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== res[127:96]) begin
      errors++; $display("FAIL enc_out_latency: got vld=%b dat=%h want 1 %h", m_axis_tvalid, m_axis_tdata, res[127:96]);
    end
    @(posedge clk); #1;
    drain(4, 1'b0, ok);
    checks++;
    if (!ok || ctrlPulses - p0 != 1) begin errors++; $display("FAIL enc_pulses: got drained=%b pulses=%0d want 1 1", ok, ctrlPulses - p0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gotBeat(k) !== expBeat(res, k)) begin errors++; $display("FAIL enc_beat%0d: got %h want %h", k, gotBeat(k), expBeat(res, k)); end
    end
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL enc_tready_after_drain: got tready=%b busy=%b want 1 0", s_axis_tready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    logic [32:0] w1;
    bit ok, okR;
    int lat, sv0;
    randWords();
    res = {$urandom, $urandom, $urandom, $urandom};
    w1 = expBeat(res, 1);
    outQ.delete();
    sv0 = stallViol;
    sendBlock(4, 2'b01, 2'b01, 1'b1, ok);
    devReply(res, 2, lat, okR);
    @(posedge clk); #1 m_axis_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== w1) begin
        errors++; $display("FAIL bp_stall%0d: got vld=%b %h want 1 %h", c, m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, w1);
      end
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
    drain(4, 1'b0, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (!okR || outQ.size() != 4 || stallViol != sv0) begin
      errors++; $display("FAIL bp_count: got reply=%b beats=%0d stallviol=%0d want 1 4 0", okR, outQ.size(), stallViol - sv0);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gotBeat(k) !== expBeat(res, k)) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", k, gotBeat(k), expBeat(res, k)); end
    end
  endtask

  task automatic test_early_tlast();
    logic [127:0] res;
    bit ok, okR;
    int lat;
    beatWords = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0, 32'h0};
    res = {$urandom, $urandom, $urandom, $urandom};
    outQ.delete();
    sendBlock(2, 2'b00, 2'b00, 1'b1, ok);
    devReply(res, 1, lat, okR);
    checks++;
    if (!ok || !okR || dev_data_in !== expBlock(2)) begin
      errors++; $display("FAIL early_tlast_block: got %h want %h", dev_data_in, expBlock(2));
    end
    drain(4, 1'b0, ok);
    checks++;
    if (!ok || gotBeat(3) !== expBeat(res, 3)) begin errors++; $display("FAIL early_tlast_out: got %h want %h", gotBeat(3), expBeat(res, 3)); end
  endtask

  task automatic test_modes();
    logic [127:0] res;
    bit ok, okR;
    int lat, p0;
    randWords();
    p0 = ctrlPulses;
    sendBlock(4, 2'b11, 2'b00, 1'b1, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ctrlPulses != p0 || err[1] !== 1'b1 || s_axis_tready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL invalid_mode: got pulses=%0d err=%b tready=%b busy=%b want 0 1x 1 0", ctrlPulses - p0, err, s_axis_tready, busy);
    end
    randWords();
    res = {$urandom, $urandom, $urandom, $urandom};
    outQ.delete();
    sendBlock(4, 2'b00, 2'b11, 1'b1, ok);
    devReply(res, 0, lat, okR);
    checks++;
    if (!okR || dev_mode !== 2'b00 || dev_data_in !== expBlock(4)) begin
      errors++; $display("FAIL first_beat_mode: got mode %b blk %h want 00 %h", dev_mode, dev_data_in, expBlock(4));
    end
    drain(4, 1'b0, ok);
    randWords();
    outQ.delete();
    sendBlock(4, 2'b10, 2'b01, 1'b0, ok);
    devReply(res, 3, lat, okR);
    checks++;
    if (!okR || dev_mode !== 2'b10) begin errors++; $display("FAIL keygen_mode: got %b want 10", dev_mode); end
    dev_data_out = {$urandom, $urandom, $urandom, $urandom};
    dev_ctrl_out = 1'b1;
    @(posedge clk); #1 dev_ctrl_out = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (outQ.size() != 0 || s_axis_tready !== 1'b1 || busy !== 1'b0 || err !== 2'b10) begin
      errors++; $display("FAIL keygen_no_output: got beats=%0d tready=%b busy=%b err=%b want 0 1 0 10", outQ.size(), s_axis_tready, busy, err);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [127:0] res;
      logic [1:0] md;
      bit ok, okR, useLast;
      int n, lat;
      n = $urandom_range(1, 4);
      useLast = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      md = 2'($urandom_range(0, 1));
      randWords();
      res = {$urandom, $urandom, $urandom, $urandom};
      outQ.delete();
      sendBlock(n, md, 2'($urandom_range(0, 3)), useLast, ok);
      devReply(res, $urandom_range(0, 6), lat, okR);
      checks++;
      if (!ok || !okR || lat != 0 || dev_data_in !== expBlock(n) || dev_mode !== md) begin
        errors++; $display("FAIL rand%0d_issue: got lat=%0d blk %h mode %b want 0 %h %b", it, lat, dev_data_in, dev_mode, expBlock(n), md);
      end
      drain(4, 1'b1, ok);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gotBeat(k) !== expBeat(res, k)) begin errors++; $display("FAIL rand%0d_beat%0d: got %h want %h", it, k, gotBeat(k), expBeat(res, k)); end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [127:0] res;
    bit ok, okR;
    int lat;
    randWords();
    res = {$urandom, $urandom, $urandom, $urandom};
    outQ.delete();
    sendBlock(4, 2'b00, 2'b00, 1'b1, ok);
    devReply(res, 0, lat, okR);
    drain(2, 1'b0, ok);
    m_axis_tready = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, dev_data_in, dev_ctrl_in, dev_mode, busy, err} !== '0) begin
      errors++; $display("FAIL mid_drain_reset_outputs: got %h want all zero", {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, dev_data_in, dev_ctrl_in, dev_mode, busy, err});
    end
    @(posedge clk); #1 resetn = 1'b1;
    m_axis_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (!ok || outQ.size() != 2 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL mid_drain_no_beats: got beats=%0d vld=%b want 2 0", outQ.size(), m_axis_tvalid);
    end
  endtask

`ifdef AES_BRIDGE_WDOG_EN
  task automatic test_watchdog();
    logic [127:0] res;
    bit ok, okR;
    int lat, bad;
    randWords();
    res = {$urandom, $urandom, $urandom, $urandom};
    outQ.delete();
    sendBlock(4, 2'b01, 2'b01, 1'b1, ok);
    devReply(res, 15, lat, okR);
    drain(4, 1'b0, ok);
    checks++;
    if (!ok || err[0] !== 1'b0 || gotBeat(0) !== expBeat(res, 0)) begin
      errors++; $display("FAIL wdog_race: got err=%b beat0=%h want 0 %h", err, gotBeat(0), expBeat(res, 0));
    end
    randWords();
    sendBlock(4, 2'b00, 2'b00, 1'b1, ok);
    @(negedge clk);
    bad = dev_ctrl_in ? 0 : 1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (err[0] !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wdog_early: got %0d bad WAIT cycles want 0", bad); end
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b1 || s_axis_tready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL wdog_timeout: got err=%b tready=%b busy=%b want x1 1 0", err, s_axis_tready, busy);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt();
    test_backpressure();
    test_early_tlast();
    test_modes();
    test_random();
    test_reset_mid_drain();
`ifdef AES_BRIDGE_WDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
